axin_chan_alloc: RTL and testbench

//  Per-output-port channel allocator and stream multiplexer for the switch

---
 rtl/axin_chan_alloc_pkg.sv | 9 +
 rtl/axin_chan_alloc_if.sv | 21 ++
 rtl/axin_rrpick.sv | 20 ++
 rtl/axin_chan_alloc.sv | 85 ++++++++
 tb/tb_axin_chan_alloc.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axin_chan_alloc_pkg.sv
// axin_chan_alloc_pkg: AXIN beat widths, allocator states and the one-hot helper
package axin_chan_alloc_pkg;
  localparam int AXIN_DW = 64;
  localparam int AXIN_WBITS = $clog2(AXIN_DW / 8);
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;
  function automatic logic [31:0] onehot(input int idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/axin_chan_alloc_if.sv
// axin_chan_alloc_if: request/grant and AXIN stream bundle for one egress port
interface axin_chan_alloc_if #(
  parameter int NIN = 4,
  parameter int DW = axin_chan_alloc_pkg::AXIN_DW,
  parameter int WBITS = $clog2(DW / 8)
);
  logic [NIN-1:0] s_chreq, s_alloc, s_valid, s_ready, s_last, s_abort;
  logic [NIN*DW-1:0] s_data;
  logic [NIN*WBITS-1:0] s_bytes;
  logic m_valid, m_ready, m_last, m_abort;
  logic [DW-1:0] m_data;
  logic [WBITS-1:0] m_bytes;
  modport master (
    output s_chreq, s_valid, s_data, s_bytes, s_last, s_abort, m_ready,
    input  s_alloc, s_ready, m_valid, m_data, m_bytes, m_last, m_abort
  );
  modport slave (
    input  s_chreq, s_valid, s_data, s_bytes, s_last, s_abort, m_ready,
    output s_alloc, s_ready, m_valid, m_data, m_bytes, m_last, m_abort
  );
endinterface

// File: rtl/axin_rrpick.sv
// axin_rrpick: one-hot grant to the first request strictly after the last grant
module axin_rrpick import axin_chan_alloc_pkg::*; #(
  parameter int NIN = 4,
  parameter int LW = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic [NIN-1:0] req,
  input  logic [LW-1:0]  last,
  output logic [NIN-1:0] grant
);
  logic [NIN-1:0] cand;
  // scan farthest to nearest so the nearest requester wins
  always_comb begin
    grant = '0;
    cand = '0;
    for (int k = NIN; k > 0; k--) begin
      cand = NIN'(onehot((int'(last) + k) % NIN));
      if (|(req & cand)) grant = cand;
    end
  end
endmodule

// File: rtl/axin_chan_alloc.sv
// axin_chan_alloc: round-robin channel allocator and registered AXIN stream mux
module axin_chan_alloc import axin_chan_alloc_pkg::*; #(
  parameter int NIN = 4,
  parameter int DW = AXIN_DW,
  parameter int WBITS = $clog2(DW / 8),
  parameter int LGTIMEOUT = 6,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input logic i_clk,
  input logic i_reset,
  input logic i_cfg_active,
  axin_chan_alloc_if.slave bus
);
  localparam int LW = (NIN > 1) ? $clog2(NIN) : 1;
  state_t state;
  logic [LW-1:0] g, rr, pick_idx;
  logic [NIN-1:0] pick;
  logic midpkt;
  logic [LGTIMEOUT-1:0] tcnt;
  logic adv, acc, fwd, l_chreq, l_abort, l_last, abort_now, release_now;
  logic [DW-1:0] l_data;
  logic [WBITS-1:0] l_bytes;
  axin_rrpick #(.NIN(NIN), .LW(LW)) u_pick (.req(bus.s_chreq), .last(rr), .grant(pick));
  always_comb begin
    pick_idx = '0;
    l_data = '0;
    l_bytes = '0;
    for (int i = 0; i < NIN; i++) begin
      if (pick[i]) pick_idx = LW'(i);
      if (g == LW'(i)) begin
        l_data = bus.s_data[i*DW +: DW];
        l_bytes = bus.s_bytes[i*WBITS +: WBITS];
      end
    end
  end
  // s_alloc is the granted-lane mask, so lane selects reduce to AND-OR
  assign adv = !bus.m_valid || bus.m_ready;
  assign l_chreq = |(bus.s_chreq & bus.s_alloc);
  assign l_abort = |(bus.s_abort & bus.s_alloc);
  assign l_last = |(bus.s_last & bus.s_alloc);
  assign bus.s_ready = (adv && i_cfg_active) ? bus.s_alloc & bus.s_chreq : '0;
  assign acc = |(bus.s_ready & bus.s_valid);
  assign fwd = acc && !l_abort;
  assign abort_now = midpkt && (l_abort || !l_chreq || !i_cfg_active);
  assign release_now = !l_chreq || !i_cfg_active || (!midpkt && &tcnt && !acc);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      g <= '0;
      rr <= LW'(NIN - 1);
      midpkt <= 1'b0;
      tcnt <= '0;
      bus.s_alloc <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data <= '0;
      bus.m_bytes <= '0;
      bus.m_last <= 1'b0;
      bus.m_abort <= 1'b0;
    end else begin
      if (adv) begin
        bus.m_valid <= fwd;
        bus.m_data <= (OPT_LOWPOWER && !fwd) ? '0 : l_data;
        bus.m_bytes <= (OPT_LOWPOWER && !fwd) ? '0 : l_bytes;
        bus.m_last <= (OPT_LOWPOWER && !fwd) ? 1'b0 : l_last;
      end
      bus.m_abort <= abort_now || (bus.m_abort && !adv);
      if (state == ST_IDLE) begin
        if (i_cfg_active && |bus.s_chreq && adv) begin
          state <= ST_GRANT;
          g <= pick_idx;
          rr <= pick_idx;
          bus.s_alloc <= pick;
          tcnt <= '0;
        end
      end else if (release_now) begin
        state <= ST_IDLE;
        bus.s_alloc <= '0;
        midpkt <= 1'b0;
      end else begin
        midpkt <= abort_now ? 1'b0 : fwd ? !l_last : midpkt;
        tcnt <= acc ? '0 : (&tcnt) ? tcnt : tcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axin_chan_alloc.sv
// tb_axin_chan_alloc: directed phases plus random traffic, scoreboarded output stream
`timescale 1ns/1ps
module tb_axin_chan_alloc;
  localparam int NIN = 4;
  localparam int DW = 64;
  localparam int WB = 3;
  localparam int PKTS = 10;
  logic clk = 0;
  logic rst = 1;
  logic cfg = 0;
  int vectors = 0;
  int miscompares = 0;
  logic abort_ok = 0;
  logic [NIN-1:0] acc_seen = '0;
  logic [NIN-1:0] prev_req = '0, prev_alloc = '0;
  logic prev_cfg = 0;
  int rr_m = NIN - 1;
  logic [67:0] q[$];
  int len[NIN], beat[NIN], gap[NIN], sent[NIN];
  axin_chan_alloc_if #(.NIN(NIN), .DW(DW), .WBITS(WB)) bus ();
  axin_chan_alloc #(.NIN(NIN), .DW(DW), .WBITS(WB), .LGTIMEOUT(3), .OPT_LOWPOWER(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_cfg_active(cfg), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [NIN-1:0] rr_pick(input logic [NIN-1:0] req, input int last);
    for (int k = 1; k <= NIN; k++)
      if (req[(last + k) % NIN]) return NIN'(1 << ((last + k) % NIN));
    return '0;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_alloc(input logic [NIN-1:0] exp, input string name);
    int n = 0;
    while (bus.s_alloc == '0 && n < 40) begin
      tick();
      n++;
    end
    check(name, bus.s_alloc, exp);
  endtask
  task automatic send_beat(input int l, input logic last, input logic ab);
    int n = 0;
    logic ok = 0;
    bus.s_data[l*DW +: DW] = {$urandom, $urandom};
    bus.s_bytes[l*WB +: WB] = WB'($urandom);
    bus.s_last[l] = last;
    bus.s_abort[l] = ab;
    bus.s_valid[l] = 1;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = bus.s_valid[l] && bus.s_ready[l];
      tick();
      n++;
    end
    bus.s_valid[l] = 0;
    bus.s_abort[l] = 0;
    check("send accepted", ok, 1);
  endtask
  task automatic new_beat(input int i);
    bus.s_data[i*DW +: DW] = {$urandom, $urandom};
    bus.s_bytes[i*WB +: WB] = WB'($urandom);
    bus.s_last[i] = (beat[i] == len[i] - 1);
  endtask
  // monitor: scoreboard on the output stream plus grant-rule checks each cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      rr_m = NIN - 1;
      prev_alloc = '0;
      prev_req = '0;
      prev_cfg = 0;
      acc_seen = '0;
    end else begin
      acc_seen = bus.s_valid & bus.s_ready;
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) check("extra beat", q.size(), 1);
        else check("beat", {bus.m_data, bus.m_bytes, bus.m_last}, q.pop_front());
      end
      if (!bus.m_valid) check("lowpower idle", {bus.m_data, bus.m_bytes, bus.m_last}, 0);
      if (!abort_ok) check("stray abort", bus.m_abort, 0);
      check("alloc onehot0", $onehot0(bus.s_alloc), 1);
      check("ready in alloc", bus.s_ready & ~bus.s_alloc, 0);
      if (bus.s_alloc != '0 && prev_alloc == '0) begin
        check("rr grant", bus.s_alloc, prev_cfg ? rr_pick(prev_req, rr_m) : '0);
        for (int i = 0; i < NIN; i++) if (bus.s_alloc[i]) rr_m = i;
      end else if (bus.s_alloc != '0) check("grant held", bus.s_alloc, prev_alloc);
      for (int i = 0; i < NIN; i++)
        if (acc_seen[i] && !bus.s_abort[i])
          q.push_back({bus.s_data[i*DW +: DW], bus.s_bytes[i*WB +: WB], bus.s_last[i]});
      prev_req = bus.s_chreq;
      prev_alloc = bus.s_alloc;
      prev_cfg = cfg;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic done;
    int ord[4] = '{3, 0, 1, 2};
    int n;
    bus.s_chreq = '0;
    bus.s_valid = '0;
    bus.s_data = '0;
    bus.s_bytes = '0;
    bus.s_last = '0;
    bus.s_abort = '0;
    bus.m_ready = 0;
    repeat (2) tick();
    check("reset outputs", {bus.s_alloc, bus.s_ready, bus.m_valid, bus.m_abort, bus.m_last, bus.m_bytes, bus.m_data}, 0);
    rst = 0;
    cfg = 1;
    bus.m_ready = 1;
    tick();
    bus.s_chreq = 4'b0100;
    tick();
    check("t1 alloc", bus.s_alloc, 4'b0100);
    send_beat(2, 0, 0);
    check("t1 latency", {bus.m_valid, bus.m_data}, {1'b1, bus.s_data[2*DW +: DW]});
    send_beat(2, 0, 0);
    send_beat(2, 1, 0);
    bus.s_chreq[2] = 0;
    tick();
    check("t1 release", bus.s_alloc, 0);
    bus.s_chreq = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_alloc(NIN'(1 << ord[k]), "t2 rr order");
      send_beat(ord[k], 1, 0);
      bus.s_chreq[ord[k]] = 0;
      tick();
      check("t2 idle gap", bus.s_alloc, 0);
    end
    bus.s_chreq[1] = 1;
    wait_alloc(4'b0010, "t3 alloc");
    send_beat(1, 0, 0);
    send_beat(1, 0, 0);
    abort_ok = 1;
    bus.s_chreq[1] = 0;
    bus.m_ready = 0;
    tick();
    check("t3 abort", {bus.m_abort, bus.s_alloc}, {1'b1, 4'b0000});
    repeat (2) tick();
    check("t3 abort held", {bus.m_abort, bus.m_valid}, 2'b11);
    bus.m_ready = 1;
    tick();
    check("t3 abort cleared", {bus.m_abort, bus.m_valid}, 2'b00);
    abort_ok = 0;
    bus.s_chreq[0] = 1;
    wait_alloc(4'b0001, "t4 alloc");
    bus.s_chreq[3] = 1;
    n = 0;
    while (bus.s_alloc == 4'b0001 && n < 50) begin
      tick();
      n++;
    end
    check("t4 timeout cycles", n, 8);
    wait_alloc(4'b1000, "t4 next grant");
    bus.s_chreq = '0;
    repeat (2) tick();
    bus.s_chreq[2] = 1;
    wait_alloc(4'b0100, "t5 alloc");
    send_beat(2, 0, 0);
    abort_ok = 1;
    bus.m_ready = 0;
    cfg = 0;
    bus.s_chreq[0] = 1;
    tick();
    check("t5 cfg abort", {bus.m_abort, bus.s_alloc}, {1'b1, 4'b0000});
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5 no grant inactive", bus.s_alloc, 0);
    end
    bus.m_ready = 1;
    tick();
    check("t5 abort cleared", bus.m_abort, 0);
    cfg = 1;
    bus.s_chreq[2] = 0;
    wait_alloc(4'b0001, "t5 regrant");
    send_beat(0, 0, 0);
    send_beat(0, 0, 1);
    check("s_abort midpkt", bus.m_abort, 1);
    tick();
    check("s_abort cleared", bus.m_abort, 0);
    abort_ok = 0;
    send_beat(0, 1, 1);
    tick();
    check("abort between pkts", {bus.m_valid, bus.m_abort}, 0);
    bus.s_chreq[0] = 0;
    bus.s_chreq[1] = 1;
    repeat (2) tick();
    wait_alloc(4'b0010, "rst alloc");
    send_beat(1, 0, 0);
    bus.m_ready = 0;
    check("rst pending beat", bus.m_valid, 1);
    #2 rst = 1;
    #1 check("async reset", {bus.s_alloc, bus.s_ready, bus.m_valid, bus.m_abort, bus.m_last, bus.m_bytes, bus.m_data}, 0);
    bus.s_chreq = '0;
    @(negedge clk);
    tick();
    rst = 0;
    for (int i = 0; i < NIN; i++) begin
      len[i] = 0;
      beat[i] = 0;
      gap[i] = 0;
      sent[i] = 0;
    end
    done = 0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      tick();
      bus.m_ready = ($urandom_range(0, 3) != 0);
      done = 1;
      for (int i = 0; i < NIN; i++) begin
        if (acc_seen[i] && len[i] != 0) begin
          beat[i]++;
          if (beat[i] == len[i]) begin
            len[i] = 0;
            bus.s_chreq[i] = 0;
            gap[i] = $urandom_range(1, 3);
            sent[i]++;
          end else new_beat(i);
        end
        if (len[i] == 0) begin
          if (gap[i] > 0) gap[i]--;
          else if (sent[i] < PKTS) begin
            len[i] = $urandom_range(1, 5);
            beat[i] = 0;
            bus.s_chreq[i] = 1;
            new_beat(i);
          end
        end
        bus.s_valid[i] = (len[i] != 0) && ($urandom_range(0, 3) != 0);
        if (sent[i] < PKTS || len[i] != 0) done = 0;
      end
    end
    check("random traffic done", done, 1);
    bus.s_valid = '0;
    bus.s_chreq = '0;
    bus.m_ready = 1;
    repeat (5) tick();
    check("scoreboard drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
